// File: rtl/reg_dump_if.sv
// Handshake/bus bundle for reg_dump: register-file read port, word stream and status.
// master = the dumper, slave = register file plus consumer.
interface reg_dump_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              i_start;
    logic [ADDR_W-1:0] i_first;
    logic [ADDR_W-1:0] i_last;
    logic [ADDR_W-1:0] o_raddr;
    logic [WIDTH-1:0]  i_rdata;
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_addr;
    logic [WIDTH-1:0]  o_data;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W:0]   o_cnt;

    modport master (
        input  i_start, i_first, i_last, i_rdata, i_ready,
        output o_raddr, o_valid, o_addr, o_data, o_busy, o_done, o_cnt
    );

    modport slave (
        output i_start, i_first, i_last, i_rdata, i_ready,
        input  o_raddr, o_valid, o_addr, o_data, o_busy, o_done, o_cnt
    );
endinterface

// File: rtl/reg_dump.sv
// Walks a register address range [first..last] (wrapping) and streams (addr, data) words.
// Optional: define REG_DUMP_SKIP_ZERO_EN to drop zero-valued entries from the stream.
module reg_dump #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic      i_clk,
    input  logic      i_rst,
    reg_dump_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_cnt;
    logic              w_hs;

    assign w_hs = r_valid & bus.i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_last  <= '0;
            r_raddr <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_last  <= bus.i_last;
                        r_raddr <= bus.i_first;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
                    if (bus.i_rdata == '0) begin
                        if (r_raddr == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_raddr <= r_raddr + 1'b1;
                        end
                    end else
`endif
                    begin
                        r_data  <= bus.i_rdata;
                        r_addr  <= r_raddr;
                        r_valid <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                        // Compare the presented address, so a wrap past the top ends exactly at last.
                        if (r_addr == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_raddr <= r_raddr + 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_raddr = r_raddr;
    assign bus.o_valid = r_valid;
    assign bus.o_addr  = r_addr;
    assign bus.o_data  = r_data;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_cnt   = r_cnt;
endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump; register file model holds 5*addr, expectations follow REG_DUMP_SKIP_ZERO_EN.
module tb_reg_dump;
    logic clk;
    logic rst;
    reg_dump_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    reg_dump #(.WIDTH(32), .ADDR_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [31:0] mem [0:31];
    assign bus.i_rdata = mem[bus.o_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [4:0]  got_addr [16];
    logic [31:0] got_data [16];
    int got_n, done_cnt, done_idx, first_vidx, stab_err;
    bit timeout;

    task automatic do_start(input logic [4:0] first, input logic [4:0] last);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_first = first;
        bus.i_last  = last;
    endtask

    // Monitor/driver: runs one dump to completion, recording handshaken words and o_done timing.
    task automatic collect(input int budget, input int stall_addr, input int stall_n, input bit busy_start);
        int stalls;
        logic [4:0]  h_addr;
        logic [31:0] h_data;
        got_n = 0; done_cnt = 0; done_idx = -1; first_vidx = -1; stab_err = 0; stalls = 0;
        h_addr = '0; h_data = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            bus.i_start = busy_start && (k == 2 || k == 4);
            if (busy_start) begin
                bus.i_first = 5'd20;
                bus.i_last  = 5'd21;
            end
            if (bus.o_valid && first_vidx < 0) first_vidx = k;
            bus.i_ready = 1'b1;
            if (bus.o_valid && int'(bus.o_addr) == stall_addr) begin
                if (stalls == 0) begin
                    h_addr = bus.o_addr;
                    h_data = bus.o_data;
                end else if (bus.o_addr !== h_addr || bus.o_data !== h_data) begin
                    stab_err++;
                end
                if (stalls < stall_n) begin
                    bus.i_ready = 1'b0;
                    stalls++;
                end
            end
            if (bus.o_valid && bus.i_ready && got_n < 16) begin
                got_addr[got_n] = bus.o_addr;
                got_data[got_n] = bus.o_data;
                got_n++;
            end
            if (bus.o_done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k;
            end
            if (done_idx >= 0 && k >= done_idx + 2) break;
        end
        timeout = (done_idx < 0);
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_raddr, bus.o_valid, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got raddr=%0d valid=%0b addr=%0d data=%0d busy=%0b done=%0b cnt=%0d want all 0",
                     bus.o_raddr, bus.o_valid, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int e_first, e_n, e_fv, e_done;
`ifdef REG_DUMP_SKIP_ZERO_EN
        e_first = 1; e_n = 3; e_fv = 2; e_done = 7;
`else
        e_first = 0; e_n = 4; e_fv = 1; e_done = 8;
`endif
        do_start(5'd0, 5'd3);
        collect(40, -1, 0, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: no o_done within budget"); end
        checks++; if (got_n !== e_n) begin errors++; $display("FAIL basic_count: got %0d words want %0d", got_n, e_n); end
        for (int i = 0; i < e_n && i < got_n; i++) begin
            checks++;
            if (got_addr[i] !== 5'(e_first + i) || got_data[i] !== 32'(5 * (e_first + i))) begin
                errors++;
                $display("FAIL basic_word%0d: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], e_first + i, 5 * (e_first + i));
            end
        end
        checks++; if (first_vidx !== e_fv) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want %0d", first_vidx, e_fv); end
        checks++; if (done_idx !== e_done) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_idx, e_done); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_width: got %0d cycles want 1", done_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (bus.o_cnt !== 6'(e_n)) begin errors++; $display("FAIL basic_cnt_hold: got %0d want %0d", bus.o_cnt, e_n); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b want 0", bus.o_busy); end
    endtask

    task automatic test_wrap;
        int ea [4];
        int e_n;
`ifdef REG_DUMP_SKIP_ZERO_EN
        ea = '{30, 31, 1, 0}; e_n = 3;
`else
        ea = '{30, 31, 0, 1}; e_n = 4;
`endif
        do_start(5'd30, 5'd1);
        collect(40, -1, 0, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wrap_timeout: no o_done within budget"); end
        checks++; if (got_n !== e_n) begin errors++; $display("FAIL wrap_count: got %0d words want %0d", got_n, e_n); end
        for (int i = 0; i < e_n && i < got_n; i++) begin
            checks++;
            if (got_addr[i] !== 5'(ea[i]) || got_data[i] !== 32'(5 * ea[i])) begin
                errors++;
                $display("FAIL wrap_word%0d: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], ea[i], 5 * ea[i]);
            end
        end
        checks++; if (bus.o_cnt !== 6'(e_n)) begin errors++; $display("FAIL wrap_cnt: got %0d want %0d", bus.o_cnt, e_n); end
    endtask

    task automatic test_backpressure;
        do_start(5'd1, 5'd4);
        collect(60, 2, 3, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout: no o_done within budget"); end
        checks++; if (got_n !== 4) begin errors++; $display("FAIL bp_count: got %0d words want 4", got_n); end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            checks++;
            if (got_addr[i] !== 5'(i + 1) || got_data[i] !== 32'(5 * (i + 1))) begin
                errors++;
                $display("FAIL bp_word%0d: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], i + 1, 5 * (i + 1));
            end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
        checks++; if (done_idx !== 11) begin errors++; $display("FAIL bp_done_cycle: got %0d want 11", done_idx); end
        checks++; if (bus.o_cnt !== 6'd4) begin errors++; $display("FAIL bp_cnt: got %0d want 4", bus.o_cnt); end
    endtask

    task automatic test_reset_mid;
        int dn;
        dn = 0;
        bus.i_ready = 1'b1;
        do_start(5'd4, 5'd8);
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_addr !== 5'd5 || bus.o_data !== 32'd25) begin
            errors++;
            $display("FAIL rstmid_second_word: got valid=%0b (%0d,%0d) want 1 (5,25)", bus.o_valid, bus.o_addr, bus.o_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_raddr, bus.o_valid, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got raddr=%0d valid=%0b addr=%0d data=%0d busy=%0b done=%0b cnt=%0d want all 0",
                     bus.o_raddr, bus.o_valid, bus.o_addr, bus.o_data, bus.o_busy, bus.o_done, bus.o_cnt);
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        rst = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", dn); end
        do_start(5'd7, 5'd7);
        collect(30, -1, 0, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: no o_done within budget"); end
        checks++;
        if (got_n !== 1 || got_addr[0] !== 5'd7 || got_data[0] !== 32'd35) begin
            errors++;
            $display("FAIL rstmid_single: got n=%0d first (%0d,%0d) want n=1 (7,35)", got_n, got_addr[0], got_data[0]);
        end
        checks++; if (bus.o_cnt !== 6'd1) begin errors++; $display("FAIL rstmid_cnt: got %0d want 1", bus.o_cnt); end
    endtask

    task automatic test_skip_zero;
        int ea [3];
        int e_n, e_n2;
        mem[2] = 32'd0;
`ifdef REG_DUMP_SKIP_ZERO_EN
        ea = '{1, 3, 0}; e_n = 2; e_n2 = 0;
`else
        ea = '{1, 2, 3}; e_n = 3; e_n2 = 1;
`endif
        do_start(5'd1, 5'd3);
        collect(40, -1, 0, 1'b0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL skip_timeout: no o_done within budget"); end
        checks++; if (got_n !== e_n) begin errors++; $display("FAIL skip_count: got %0d words want %0d", got_n, e_n); end
        for (int i = 0; i < e_n && i < got_n; i++) begin
            checks++;
            if (got_addr[i] !== 5'(ea[i]) || got_data[i] !== mem[ea[i]]) begin
                errors++;
                $display("FAIL skip_word%0d: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], ea[i], mem[ea[i]]);
            end
        end
        checks++; if (bus.o_cnt !== 6'(e_n)) begin errors++; $display("FAIL skip_cnt: got %0d want %0d", bus.o_cnt, e_n); end
        do_start(5'd2, 5'd2);
        collect(30, -1, 0, 1'b0);
        checks++; if (timeout !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL skip_last_done: got done=%0d timeout=%0b want 1 0", done_cnt, timeout); end
        checks++; if (got_n !== e_n2 || bus.o_cnt !== 6'(e_n2)) begin errors++; $display("FAIL skip_last_cnt: got n=%0d cnt=%0d want %0d", got_n, bus.o_cnt, e_n2); end
        mem[2] = 32'd10;
    endtask

    task automatic test_busy_start;
        int e_first, e_n;
`ifdef REG_DUMP_SKIP_ZERO_EN
        e_first = 1; e_n = 3;
`else
        e_first = 0; e_n = 4;
`endif
        do_start(5'd0, 5'd3);
        collect(40, -1, 0, 1'b1);
        checks++; if (timeout !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL busy_done: got done=%0d timeout=%0b want 1 0", done_cnt, timeout); end
        checks++; if (got_n !== e_n) begin errors++; $display("FAIL busy_count: got %0d words want %0d", got_n, e_n); end
        for (int i = 0; i < e_n && i < got_n; i++) begin
            checks++;
            if (got_addr[i] !== 5'(e_first + i) || got_data[i] !== 32'(5 * (e_first + i))) begin
                errors++;
                $display("FAIL busy_word%0d: got (%0d,%0d) want (%0d,%0d)", i, got_addr[i], got_data[i], e_first + i, 5 * (e_first + i));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_cnt !== 6'(e_n)) begin
            errors++;
            $display("FAIL busy_after: got busy=%0b cnt=%0d want 0 %0d", bus.o_busy, bus.o_cnt, e_n);
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 32'(5 * a);
        bus.i_start = 1'b0;
        bus.i_first = '0;
        bus.i_last  = '0;
        bus.i_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_skip_zero();
        test_busy_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
